// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select scheduler.
//   NUM_CH  : number of mux channels
//   SEL_W   : width of the binary select
//   state_t : scheduler states (IDLE, HOLD)
//   onehot  : binary index to one-hot grant decode
package mux_sel_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [0:0] {
        IDLE,
        HOLD
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search, purely combinational.
//   req   : per-channel request bits
//   last  : channel served most recently
//   next  : first requesting channel after last (wrapping, last itself checked last)
//   found : high when any request bit is set
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        next  = last;
        found = 1'b0;
        cand  = '0;
        // Offsets 1..NUM_CH; offset NUM_CH wraps back onto last so a sole
        // requester that was just served is still granted.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = last + SEL_W'(k);
            if (!found && req[cand]) begin
                next  = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sched.sv
// Round-robin select scheduler for a 4:1 channel mux.
// Each granted channel holds the select for DWELL_CYCLES clocks; idle
// channels are skipped and windows run back-to-back with no bubble.
// All outputs are registered so the downstream select never glitches.
//
// Optional feature: define MUX_SEL_LOCK_EN to add the lock input, which
// re-grants the current channel for another window at its end.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   en        : scheduler run enable
//   req       : per-channel request
//   lock      : re-grant current channel (MUX_SEL_LOCK_EN only)
//   s         : binary mux select
//   grant     : one-hot grant, zero when idle
//   busy      : high while a dwell window is active
//   slot_done : pulse on the last cycle of each window
module mux_sel_sched
    import mux_sel_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
`ifdef MUX_SEL_LOCK_EN
    input  logic              lock,
`endif
    output logic [SEL_W-1:0]  s,
    output logic [NUM_CH-1:0] grant,
    output logic              busy,
    output logic              slot_done
);

    localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(DWELL_CYCLES - 1);
    // A one-cycle window ends on the same cycle it starts.
    localparam logic             RELOAD_DONE = (DWELL_CYCLES == 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic             relock;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last),
        .next  (pick),
        .found (found)
    );

`ifdef MUX_SEL_LOCK_EN
    assign relock = lock & req[s];
`else
    assign relock = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            slot_done <= 1'b0;
            cnt       <= '0;
            last      <= SEL_W'(NUM_CH - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && found) begin
                        state     <= HOLD;
                        s         <= pick;
                        grant     <= onehot(pick);
                        busy      <= 1'b1;
                        cnt       <= RELOAD;
                        slot_done <= RELOAD_DONE;
                        last      <= pick;
                    end else begin
                        // s deliberately holds its previous value.
                        grant     <= '0;
                        busy      <= 1'b0;
                        slot_done <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt       <= cnt - CNT_W'(1);
                        slot_done <= (cnt == CNT_W'(1));
                    end else if (relock) begin
                        // Same channel again; last stays put so rotation
                        // resumes from where it would have.
                        cnt       <= RELOAD;
                        slot_done <= RELOAD_DONE;
                    end else if (en && found) begin
                        s         <= pick;
                        grant     <= onehot(pick);
                        cnt       <= RELOAD;
                        slot_done <= RELOAD_DONE;
                        last      <= pick;
                    end else begin
                        state     <= IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        slot_done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sched.sv
module tb_mux_sel_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       lock;

    logic [1:0] s4, s1;
    logic [3:0] grant4, grant1;
    logic       busy4, busy1, slot4, slot1;

    int n_assert = 0;
    int n_fail   = 0;

    mux_sel_sched #(.DWELL_CYCLES(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
`ifdef MUX_SEL_LOCK_EN
        .lock      (lock),
`endif
        .s         (s4),
        .grant     (grant4),
        .busy      (busy4),
        .slot_done (slot4)
    );

    mux_sel_sched #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
`ifdef MUX_SEL_LOCK_EN
        .lock      (lock),
`endif
        .s         (s1),
        .grant     (grant1),
        .busy      (busy1),
        .slot_done (slot1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a window is "cur channel, cycles left including this one".
    typedef struct {
        bit act;
        int cur;
        int left;
        int last;
    } mst_t;

    function automatic mst_t m_reset();
        mst_t m;
        m.act  = 1'b0;
        m.cur  = 0;
        m.left = 0;
        m.last = 3;
        return m;
    endfunction

    function automatic mst_t m_step(mst_t m, logic e, logic [3:0] r, logic lk, int dwell);
        mst_t n;
        n = m;
        if (m.act && m.left > 1) begin
            n.left = m.left - 1;
        end else if (m.act && lk && r[m.cur]) begin
            n.left = dwell;
        end else if (e && r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m.last + k) % 4;
                if (r[c]) begin
                    n.cur = c;
                    break;
                end
            end
            n.act  = 1'b1;
            n.last = n.cur;
            n.left = dwell;
        end else begin
            n.act = 1'b0;
        end
        return n;
    endfunction

    mst_t m4, m1;

    logic lk_eff;
`ifdef MUX_SEL_LOCK_EN
    assign lk_eff = lock;
`else
    assign lk_eff = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 <= m_reset();
            m1 <= m_reset();
        end else begin
            m4 <= m_step(m4, en, req, lk_eff, 4);
            m1 <= m_step(m1, en, req, lk_eff, 1);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        chk("s4",     int'(s4),     m4.cur);
        chk("grant4", int'(grant4), m4.act ? (1 << m4.cur) : 0);
        chk("busy4",  int'(busy4),  int'(m4.act));
        chk("slot4",  int'(slot4),  (m4.act && m4.left == 1) ? 1 : 0);
        chk("s1",     int'(s1),     m1.cur);
        chk("grant1", int'(grant1), m1.act ? (1 << m1.cur) : 0);
        chk("busy1",  int'(busy1),  int'(m1.act));
        chk("slot1",  int'(slot1),  (m1.act && m1.left == 1) ? 1 : 0);
    end

    int exp_s;

    initial begin
        int alt [4];
        alt = '{3, 1, 3, 1};
        rst  = 1'b1;
        en   = 1'b0;
        req  = 4'b0000;
        lock = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        req = 4'b1111;
        en  = 1'b1;

        // Full rotation 0,1,2,3,0 with four cycles each.
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                chk("rot_s",     int'(s4),     w % 4);
                chk("rot_grant", int'(grant4), 1 << (w % 4));
                chk("rot_slot",  int'(slot4),  (c == 3) ? 1 : 0);
            end
        end

        // Drop req and en in the 2nd cycle of the ch1 window.
        @(posedge clk); #1;
        chk("drop_s_c1", int'(s4), 1);
        @(posedge clk); #1;
        chk("drop_s_c2", int'(s4), 1);
        #1;
        req = 4'b0000;
        en  = 1'b0;
        @(posedge clk); #1;
        chk("drop_busy_c3", int'(busy4), 1);
        chk("drop_slot_c3", int'(slot4), 0);
        @(posedge clk); #1;
        chk("drop_slot_c4", int'(slot4), 1);
        chk("drop_grant_c4", int'(grant4), 4'b0010);
        @(posedge clk); #1;
        chk("drop_busy_after",  int'(busy4),  0);
        chk("drop_grant_after", int'(grant4), 0);
        chk("drop_s_held",      int'(s4),     1);
        chk("drop_slot_after",  int'(slot4),  0);

        // Skip idle channels: 1010 from last=1 gives 3,1,3,1.
        #1;
        req = 4'b1010;
        en  = 1'b1;
        for (int w = 0; w < 4; w++) begin
            @(posedge clk); #1;
            chk("skip_s", int'(s4), alt[w]);
            if (w == 3) begin
                #1;
                req = 4'b0100;
            end
            repeat (3) @(posedge clk);
        end

        // Sole requester keeps the select across windows.
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            chk("sole_s",     int'(s4),     2);
            chk("sole_grant", int'(grant4), 4'b0100);
            repeat (3) @(posedge clk);
        end

        // One-cycle windows toggle 0001/0010 every clock.
        #2;
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("d1_grant", int'(grant1), (k % 2 == 0) ? 4'b0001 : 4'b0010);
            chk("d1_slot",  int'(slot1),  1);
        end

        // Asynchronous reset mid-window takes effect without a clock edge.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_s",     int'(s4),     0);
        chk("arst_grant", int'(grant4), 0);
        chk("arst_busy",  int'(busy4),  0);
        chk("arst_slot",  int'(slot4),  0);
        @(posedge clk); #2;
        rst = 1'b0;
        req = 4'b1111;
        en  = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_grant", int'(grant4), 4'b0001);
        chk("post_rst_s",     int'(s4),     0);
        chk("post_rst_busy",  int'(busy4),  1);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            lock = ($urandom_range(0, 3) == 0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_sched.md
# mux_sel_sched

Round-robin select scheduler that drives the 2-bit select and one-hot grant of the 4:1 channel mux directly downstream. Each requesting channel gets a fixed dwell window of DWELL_CYCLES clocks. Idle channels are skipped. All outputs are registered, so the mux select never glitches.

## Interface
- DWELL_CYCLES, default 4: clocks each granted channel holds the select; legal range 1..255.
- CNT_W, default 8: dwell counter width; must satisfy DWELL_CYCLES ≤ 2^CNT_W − 1.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  scheduler run enable, sampled each rising edge.
- req  input  4  per-channel request, bit i = channel i.
- s  output  2  mux select, binary channel index.
- grant  output  4  one-hot grant; all zero when idle.
- busy  output  1  high while a dwell window is active.
- slot_done  output  1  one-cycle pulse on the last cycle of each dwell window.
- lock  input  1  only present when MUX_SEL_LOCK_EN is defined (see Configuration).

## Operation
- States: IDLE, HOLD.
- Reset (async assert) forces:
  - state = IDLE, s = 2'b00, grant = 4'b0000, busy = 0, slot_done = 0.
  - Internal last-served pointer = 3, so channel 0 has first priority.
- IDLE:
  - If en = 1 and req ≠ 0, pick the first set req bit searching last+1, last+2, … modulo 4.
  - Load s = picked index, grant = one-hot(picked), busy = 1, dwell counter = DWELL_CYCLES − 1, last = picked.
  - Go to HOLD.
  - Otherwise stay in IDLE. s keeps its previous value; grant = 0.
- HOLD:
  - If counter ≠ 0, decrement it. s and grant are held.
  - When counter = 0, slot_done = 1 for that cycle.
  - At the next edge, if en = 1 and req ≠ 0, pick the next channel immediately (back-to-back, no idle bubble) and reload the counter.
  - Otherwise return to IDLE: busy = 0, grant = 0.
- A window is never aborted:
  - If the granted channel's req drops mid-window, the window still completes.
  - If en drops mid-window, the window completes, then the block returns to IDLE.
- Selection rules:
  - A sole requester that was last served is granted again (wrap-around: search reaches last itself after three misses).
  - req changes during HOLD affect only the next pick.
- DWELL_CYCLES = 1:
  - Every window is one cycle long.
  - slot_done is high on every HOLD cycle.
  - Grants rotate every clock while requests persist.

## Timing
- Latency from req/en sampled high in IDLE to s/grant/busy valid: 1 clock edge.
- Window length is exactly DWELL_CYCLES cycles, from the first grant cycle through the slot_done cycle.
- Back-to-back windows have 0 gap cycles. With continuous requests, grant changes on the edge right after slot_done.
- Reset deasserted mid-operation: the first pick happens on the first edge with rst low and en & |req, and it targets channel 0.
- Async rst asserted mid-window: outputs go to their reset values immediately, without waiting for clk.

## Configuration
- MUX_SEL_LOCK_EN defined:
  - Adds the lock input.
  - If lock = 1 on the slot_done cycle and the current channel's req = 1, that channel is re-granted for another full window. last is unchanged and slot_done still pulses.
- MUX_SEL_LOCK_EN undefined:
  - The lock port does not exist.
  - Rotation is strictly fair as described under Operation.

## Structure
- Package mux_sel_pkg holds:
  - NUM_CH = 4, SEL_W = 2.
  - The state enum typedef (IDLE, HOLD).
  - The one-hot decode function.
- Sub-module rr_pick is purely combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: next[1:0], found.
  - It is instantiated once for the rotating priority search.

## Test plan
- Reset: rst = 1 mid-window → s = 0, grant = 0, busy = 0, slot_done = 0 immediately. After release with req = 4'b1111, en = 1 → first grant = 4'b0001.
- Full rotation: req = 4'b1111, en = 1, DWELL_CYCLES = 4 → s sequence 0,1,2,3,0 with 4 cycles each, slot_done on cycles 4, 8, 12, 16, no gaps.
- Skip idle: req = 4'b1010 → s alternates 1,3,1,3. Single req = 4'b0100 → s stays 2 across consecutive windows.
- Mid-window drop: req goes to 0 and en goes to 0 in the 2nd cycle of a window → the window finishes all 4 cycles, slot_done pulses, next cycle busy = 0 and grant = 0 with s held.
- DWELL_CYCLES = 1 with req = 4'b0011 → grant toggles 0001/0010 every clock, slot_done constantly high.
- Lock (MUX_SEL_LOCK_EN): lock = 1 at slot_done with ch1 granted and req = 4'b0011 → ch1 re-granted for 4 more cycles; lock = 0 → ch0 next.
